ps2_receiver: RTL and testbench

- Receives PS/2 keyboard frames on the raw kclk/kdata lines, all in the clk domain.
- Extracts each 8-bit scancode and shifts it into a 4-byte history register, keycodeout, with the newest byte in [7:0].
- Sits between the keyboard pins and the key decoder. The decoder interprets make, break (F0) and extended (E0) sequences from the history.

---
 rtl/ps2_if.sv | 10 +
 rtl/ps2_receiver.sv | 133 +++++++++++++
 tb/tb_ps2_receiver.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/ps2_if.sv
// PS/2 pin pair plus the scancode history it produces.
// The master side is the keyboard/board; the slave side is the receiver.
interface ps2_if;
    logic        kclk;
    logic        kdata;
    logic [31:0] keycodeout;

    modport master (output kclk, output kdata, input keycodeout);
    modport slave  (input kclk, input kdata, output keycodeout);
endinterface

// File: rtl/ps2_receiver.sv
// PS/2 frame receiver: synchronises and de-glitches kclk/kdata, captures
// 11-bit frames and shifts each accepted scancode into a 4-byte history.
module ps2_receiver #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 20000
) (
    input  logic   clk,
    input  logic   rst,
    ps2_if.slave   ps2
);

    localparam int unsigned FCW      = $clog2(FILTER_LEN + 1);
    localparam int unsigned TCW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned BCW      = 4;
    localparam int unsigned SHW      = 10;
    localparam int unsigned KCW      = 32;
    localparam int unsigned LAST_BIT = 10;

    typedef enum logic [0:0] {
        S_IDLE,
        S_RECV
    } state_t;

    // Index 0 is kclk, index 1 is kdata.
    logic [1:0]     raw;
    logic [1:0]     meta_q;
    logic [1:0]     sync_q;
    logic [1:0]     filt_q;
    logic [FCW-1:0] fcnt_q [2];
    logic           kclk_prev_q;
    logic           fall;

    state_t         state_q,   state_d;
    logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
    logic [SHW-1:0] shift_q,   shift_d;
    logic [TCW-1:0] tcnt_q,    tcnt_d;
    logic [KCW-1:0] keycode_q, keycode_d;

    assign raw = {ps2.kdata, ps2.kclk};

    // Two-flop synchroniser followed by a run-length glitch filter per line.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q      <= 2'b11;
            sync_q      <= 2'b11;
            filt_q      <= 2'b11;
            kclk_prev_q <= 1'b1;
            for (int i = 0; i < 2; i++) fcnt_q[i] <= '0;
        end else begin
            meta_q      <= raw;
            sync_q      <= meta_q;
            kclk_prev_q <= filt_q[0];
            for (int i = 0; i < 2; i++) begin
                if (sync_q[i] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == FCW'(FILTER_LEN - 1)) begin
                    filt_q[i] <= sync_q[i];
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + FCW'(1);
                end
            end
        end
    end

    assign fall = kclk_prev_q & ~filt_q[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tcnt_q    <= '0;
            keycode_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tcnt_q    <= tcnt_d;
            keycode_q <= keycode_d;
        end
    end

    // Frame capture: shift_q collects start, D0..D7, parity (LSB first);
    // the stop bit is judged live on the eleventh sample.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tcnt_d    = tcnt_q;
        keycode_d = keycode_q;

        case (state_q)
            S_IDLE: begin
                tcnt_d = '0;
                if (fall) begin
                    shift_d   = {filt_q[1], shift_q[SHW-1:1]};
                    bit_cnt_d = BCW'(1);
                    state_d   = S_RECV;
                end
            end
            S_RECV: begin
                if (fall) begin
                    tcnt_d = '0;
                    if (bit_cnt_q == BCW'(LAST_BIT)) begin
                        if (!shift_q[0] && filt_q[1]) begin
                            keycode_d = {keycode_q[23:0], shift_q[8:1]};
                        end
                        bit_cnt_d = '0;
                        state_d   = S_IDLE;
                    end else begin
                        shift_d   = {filt_q[1], shift_q[SHW-1:1]};
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end else if (tcnt_q >= TCW'(TIMEOUT_CYCLES - 1)) begin
                    // Keyboard stalled mid-frame: drop the partial frame.
                    tcnt_d    = TCW'(TIMEOUT_CYCLES);
                    bit_cnt_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    tcnt_d = tcnt_q + TCW'(1);
                end
            end
            default: begin
                state_d   = S_IDLE;
                bit_cnt_d = '0;
            end
        endcase
    end

    assign ps2.keycodeout = keycode_q;

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed PS/2 stimulus with a scoreboard of expected history updates.
// Keyboard timing is scaled down (200 ns half-period, 2 us timeout) to keep runs short.
`timescale 1ns/1ps
module tb_ps2_receiver;

    logic clk;
    logic rst;
    ps2_if bus ();

    ps2_receiver #(.FILTER_LEN(8), .TIMEOUT_CYCLES(200)) dut (
        .clk (clk),
        .rst (rst),
        .ps2 (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [31:0] exp_q [$];
    logic [31:0] last_kc;
    logic [31:0] e;
    bit          mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, req);
        end
    endtask

    // Monitor: every change of the history must match the next queued value.
    always @(negedge clk) begin
        if (mon_en && (bus.keycodeout != last_kc)) begin
            last_kc = bus.keycodeout;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_update: got %08h, expected no update", last_kc);
            end else begin
                e = exp_q.pop_front();
                check("scoreboard", last_kc, e);
            end
        end
    end

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            bus.kdata = f[i];
            bus.kclk  = 1'b1;
            #200;
            bus.kclk  = 1'b0;
            #200;
        end
        bus.kclk  = 1'b1;
        bus.kdata = 1'b1;
    endtask

    function automatic logic [10:0] frame(input logic [7:0] d, input logic stop);
        return {stop, ^d, d, 1'b0};
    endfunction

    // acc: frame should be accepted; exp: hand-computed history afterwards.
    task automatic send_byte(input string name, input logic [7:0] d, input logic stop,
                             input bit acc, input logic [31:0] exp);
        if (acc) exp_q.push_back(exp);
        send_bits(frame(d, stop), 11);
        #1000;
        check(name, bus.keycodeout, exp);
    endtask

    initial begin
        rst       = 1'b1;
        bus.kclk  = 1'b1;
        bus.kdata = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_state", bus.keycodeout, 32'h0);
        last_kc = 32'h0;
        mon_en  = 1'b1;
        #500;

        send_byte("single_1C",  8'h1C, 1'b1, 1'b1, 32'h0000001C);
        send_byte("hist_23",    8'h23, 1'b1, 1'b1, 32'h00001C23);
        send_byte("hist_2B",    8'h2B, 1'b1, 1'b1, 32'h001C232B);
        send_byte("break_F0",   8'hF0, 1'b1, 1'b1, 32'h1C232BF0);
        send_byte("break_1C",   8'h1C, 1'b1, 1'b1, 32'h232BF01C);
        send_byte("ext_E0",     8'hE0, 1'b1, 1'b1, 32'h2BF01CE0);
        send_byte("ext_6B",     8'h6B, 1'b1, 1'b1, 32'hF01CE06B);
        send_byte("extrel_E0",  8'hE0, 1'b1, 1'b1, 32'h1CE06BE0);
        send_byte("extrel_F0",  8'hF0, 1'b1, 1'b1, 32'hE06BE0F0);
        send_byte("extrel_6B",  8'h6B, 1'b1, 1'b1, 32'h6BE0F06B);
        send_byte("key_29",     8'h29, 1'b1, 1'b1, 32'hE0F06B29);
        send_byte("key_12",     8'h12, 1'b1, 1'b1, 32'hF06B2912);
        send_byte("ext2_E0",    8'hE0, 1'b1, 1'b1, 32'h6B2912E0);
        send_byte("ext2_75",    8'h75, 1'b1, 1'b1, 32'h2912E075);

        send_byte("bad_stop_55", 8'h55, 1'b0, 1'b0, 32'h2912E075);

        // Partial frame, then idle past the timeout.
        send_bits(frame(8'h3C, 1'b1), 5);
        #3000;
        check("partial_no_update", bus.keycodeout, 32'h2912E075);
        send_byte("after_timeout_3C", 8'h3C, 1'b1, 1'b1, 32'h12E0753C);

        // Short kclk glitches must be filtered out.
        for (int i = 0; i < 6; i++) begin
            bus.kclk = 1'b0;
            #50;
            bus.kclk = 1'b1;
            #500;
        end
        #3000;
        check("glitch_no_change", bus.keycodeout, 32'h12E0753C);

        // Reset in the middle of a frame.
        send_bits(frame(8'h55, 1'b1), 5);
        exp_q.push_back(32'h0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_mid_frame", bus.keycodeout, 32'h0);
        #500;
        send_byte("post_reset_1C", 8'h1C, 1'b1, 1'b1, 32'h0000001C);
        send_byte("repeat_1C_a",   8'h1C, 1'b1, 1'b1, 32'h00001C1C);
        send_byte("repeat_1C_b",   8'h1C, 1'b1, 1'b1, 32'h001C1C1C);

        #1000;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_updates: got %0d left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
